// File: rtl/sram_controller_pkg.sv
// sram_controller_pkg
// Shared definitions for the SRAM controller: FSM state encoding, the
// data-memory base address that maps to SRAM halfword 0, and bus widths.
package sram_controller_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [31:0] DMEM_BASE   = 32'd1024;
  localparam int          WORD_W      = 32;
  localparam int          SRAM_ADDR_W = 18;
  localparam int          SRAM_DATA_W = 16;
  // Wide enough for any phase length up to 15 cycles.
  localparam int          CNT_W       = 4;

endpackage

// File: rtl/sram_phase_counter.sv
// sram_phase_counter
// Times one SRAM access phase: counts 0..WAIT_CYCLES-1 while enabled.
// Ports:
//   clk    - clock
//   rst    - asynchronous active-low reset
//   clear  - synchronous clear, asserted on every phase change
//   enable - count while a LO/HI phase is active
//   last   - current cycle is the final cycle of the phase
module sram_phase_counter
  import sram_controller_pkg::*;
#(
  parameter int WAIT_CYCLES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic last
);

  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= last ? '0 : r_count + CNT_W'(1);
    end
  end

  assign last = (r_count == LAST_VAL);

endmodule

// File: rtl/sram_controller.sv
// sram_controller
// Splits each 32-bit load/store from the MEM stage into two 16-bit SRAM
// accesses (LO then HI halfword), each lasting WAIT_CYCLES cycles.
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   wr_en, rd_en        - store / load request (store wins when both set)
//   address, write_data - byte address and store data
//   read_data           - assembled load word, held until the next load
//   ready               - low while an access is in progress
//   sram_addr           - SRAM halfword address
//   sram_dq_in/out/oe   - SRAM data bus (read, write, drive enable)
//   sram_we_n           - SRAM write strobe, active-low
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int WAIT_CYCLES = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [WORD_W-1:0]      address,
  input  logic [WORD_W-1:0]      write_data,
  output logic [WORD_W-1:0]      read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [WORD_W-1:0]      r_addr;
  logic [WORD_W-1:0]      r_wdata;
  logic [WORD_W-1:0]      r_read_data;
  logic [SRAM_ADDR_W-2:0] w_index;
  logic                   w_last;
  logic                   w_clear;
  logic                   w_enable;

  // Word index within the SRAM: byte offset from the data-memory base,
  // divided by four. Addresses below the base wrap modulo 2^32.
  assign w_index = (SRAM_ADDR_W-1)'((r_addr - DMEM_BASE) >> 2);

  assign w_enable = (r_state == RD_LO) || (r_state == RD_HI) ||
                    (r_state == WR_LO) || (r_state == WR_HI);
  // Restart the phase timer whenever the state moves on.
  assign w_clear  = (r_state != w_state_next);

  sram_phase_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_phase_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_clear),
    .enable (w_enable),
    .last   (w_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Bus outputs decode straight from the state register, so an
  // asynchronous reset releases the write strobe in the same instant.
  always_comb begin
    w_state_next = r_state;
    sram_addr    = '0;
    sram_dq_out  = '0;
    sram_dq_oe   = 1'b0;
    sram_we_n    = 1'b1;
    case (r_state)
      IDLE: begin
        if (wr_en) begin
          w_state_next = WR_LO;
        end else if (rd_en) begin
          w_state_next = RD_LO;
        end
      end
      RD_LO: begin
        sram_addr = {w_index, 1'b0};
        if (w_last) w_state_next = RD_HI;
      end
      RD_HI: begin
        sram_addr = {w_index, 1'b1};
        if (w_last) w_state_next = DONE;
      end
      WR_LO: begin
        sram_addr   = {w_index, 1'b0};
        sram_dq_out = r_wdata[15:0];
        sram_dq_oe  = 1'b1;
        sram_we_n   = 1'b0;
        if (w_last) w_state_next = WR_HI;
      end
      WR_HI: begin
        sram_addr   = {w_index, 1'b1};
        sram_dq_out = r_wdata[31:16];
        sram_dq_oe  = 1'b1;
        sram_we_n   = 1'b0;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Request capture: later changes on the inputs cannot disturb an access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (r_state == IDLE) begin
      if (wr_en) begin
        r_addr  <= address;
        r_wdata <= write_data;
      end else if (rd_en) begin
        r_addr  <= address;
      end
    end
  end

  // Sample the SRAM at the end of each read phase, when the data has had
  // the full phase to settle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_read_data <= '0;
    end else if (w_last) begin
      if (r_state == RD_LO) begin
        r_read_data[15:0] <= sram_dq_in;
      end else if (r_state == RD_HI) begin
        r_read_data[31:16] <= sram_dq_in;
      end
    end
  end

  assign read_data = r_read_data;
  assign ready     = ((r_state == IDLE) && !wr_en && !rd_en) || (r_state == DONE);

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller
// Directed table of load/store transactions against a behavioural SRAM,
// plus hand sequences for a held request and a reset in mid-write.
module tb_sram_controller;

  localparam int W = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_in;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic        sram_we_n;

  int checks = 0;
  int errors = 0;

  sram_controller #(
    .WAIT_CYCLES(W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_dq_in  (sram_dq_in),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_we_n   (sram_we_n)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: synchronous write on the strobe, asynchronous read.
  logic [15:0] mem [0:1023];
  always @(posedge clk) begin
    if (!sram_we_n) mem[sram_addr[9:0]] <= sram_dq_out;
  end
  assign sram_dq_in = mem[sram_addr[9:0]];

  typedef struct {
    logic        wr;
    logic        rd;
    int          hold;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [17:0] exp_lo;
    logic [31:0] exp_read;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one request at cycle 0, hold it for 'hold' cycles, then watch
  // each cycle until ready returns (DONE). Returns at the DONE negedge
  // with the request inputs still held if hold extends past DONE.
  task automatic run_access(input logic wr, input logic rd, input logic [31:0] addr,
                            input logic [31:0] wdata, input int hold,
                            input logic [17:0] exp_lo, input logic [31:0] exp_read,
                            input string tag);
    int   low;
    int   lo_ok;
    int   hi_ok;
    logic done;
    logic [15:0] dq_lo;
    logic [15:0] dq_hi;
    low   = 0;
    lo_ok = 0;
    hi_ok = 0;
    done  = 1'b0;
    dq_lo = wdata[15:0];
    dq_hi = wdata[31:16];
    @(posedge clk); #1;
    wr_en      = wr;
    rd_en      = rd;
    address    = addr;
    write_data = wdata;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (ready) begin
        done = 1'b1;
        check({tag, " read_data"}, read_data, exp_read);
        check({tag, " done_strobe"}, {30'b0, sram_we_n, sram_dq_oe}, 32'h2);
      end else begin
        low++;
        if (k >= 1 && k <= W) begin
          if (sram_addr == exp_lo && sram_we_n == !wr && sram_dq_oe == wr &&
              (!wr || sram_dq_out == dq_lo)) lo_ok++;
        end else if (k > W && k <= 2 * W) begin
          if (sram_addr == (exp_lo | 18'h1) && sram_we_n == !wr && sram_dq_oe == wr &&
              (!wr || sram_dq_out == dq_hi)) hi_ok++;
        end
        @(posedge clk); #1;
        if (k + 1 >= hold) begin
          wr_en = 1'b0;
          rd_en = 1'b0;
        end
      end
    end
    check({tag, " completed"}, {31'b0, done}, 32'h1);
    check({tag, " ready_low_cycles"}, low, 2 * W + 1);
    check({tag, " lo_phase_cycles"}, lo_ok, W);
    check({tag, " hi_phase_cycles"}, hi_ok, W);
    $display("txn %s: wr=%0b rd=%0b addr=%0d wdata=%h read_data=%h ready_low=%0d",
             tag, wr, rd, addr, wdata, read_data, low);
  endtask

  initial begin
    int   low;
    logic done;

    vecs[0] = '{1'b1, 1'b0, 1, 32'd1028, 32'hDEADBEEF, 18'h00002, 32'h00000000};
    vecs[1] = '{1'b0, 1'b1, 1, 32'd1028, 32'h00000000, 18'h00002, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 1'b1, 1, 32'd1032, 32'h12345678, 18'h00004, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 1'b1, 1, 32'd1032, 32'h00000000, 18'h00004, 32'h12345678};
    vecs[4] = '{1'b1, 1'b0, 2, 32'd1024, 32'hCAFEF00D, 18'h00000, 32'h12345678};
    vecs[5] = '{1'b0, 1'b1, 1, 32'd1024, 32'h00000000, 18'h00000, 32'hCAFEF00D};
    vecs[6] = '{1'b1, 1'b0, 1, 32'd1020, 32'hA5A55A5A, 18'h3FFFE, 32'hCAFEF00D};
    vecs[7] = '{1'b0, 1'b1, 1, 32'd1020, 32'h00000000, 18'h3FFFE, 32'hA5A55A5A};

    // Held in reset
    #2;
    check("rst ready",     {31'b0, ready},      32'h1);
    check("rst we_n",      {31'b0, sram_we_n},  32'h1);
    check("rst dq_oe",     {31'b0, sram_dq_oe}, 32'h0);
    check("rst read_data", read_data,           32'h0);
    check("rst sram_addr", {14'b0, sram_addr},  32'h0);
    check("rst dq_out",    {16'b0, sram_dq_out}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst ready",     {31'b0, ready},     32'h1);
    check("post_rst we_n",      {31'b0, sram_we_n}, 32'h1);
    check("post_rst read_data", read_data,          32'h0);

    for (int i = 0; i < 8; i++) begin
      run_access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].hold,
                 vecs[i].exp_lo, vecs[i].exp_read, $sformatf("v%0d", i));
    end

    // Request held through DONE starts a second access.
    run_access(1'b0, 1'b1, 32'd1028, 32'h0, 13, 18'h00002, 32'hDEADBEEF, "held");
    @(negedge clk);
    check("held restart_ready", {31'b0, ready}, 32'h0);
    @(posedge clk); #1;
    rd_en = 1'b0;
    low  = 0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (ready) done = 1'b1;
      else low++;
    end
    check("held second_low_cycles", low, 2 * W);
    check("held second_read_data", read_data, 32'hDEADBEEF);
    $display("txn held: second access ready_low=%0d read_data=%h", low, read_data);

    // Reset asserted in the third cycle of WR_HI.
    @(posedge clk); #1;
    wr_en      = 1'b1;
    address    = 32'd1036;
    write_data = 32'h0BADF00D;
    @(posedge clk); #1;
    wr_en = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("midrst pre_we_n", {31'b0, sram_we_n}, 32'h0);
    check("midrst pre_addr", {14'b0, sram_addr}, 32'd7);
    rst = 1'b0;
    #1;
    check("midrst we_n",      {31'b0, sram_we_n},   32'h1);
    check("midrst dq_oe",     {31'b0, sram_dq_oe},  32'h0);
    check("midrst ready",     {31'b0, ready},       32'h1);
    check("midrst read_data", read_data,            32'h0);
    check("midrst sram_addr", {14'b0, sram_addr},   32'h0);
    $display("txn midrst: we_n=%0b oe=%0b ready=%0b", sram_we_n, sram_dq_oe, ready);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst idle_ready", {31'b0, ready}, 32'h1);

    // Both halves of the aborted store reached the SRAM before reset.
    run_access(1'b0, 1'b1, 32'd1036, 32'h0, 1, 18'h00006, 32'h0BADF00D, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
